// File: rtl/ft_burst_sched.sv
// ft_burst_sched: schedules FT600 bursts between N_CH device-to-host FIFOs
// and one host-to-device FIFO. Reads from the host win over writes; write
// channels are served round-robin, with a flush timer so that a partly
// filled FIFO is eventually drained. All strobes leave the block from flops.
module ft_burst_sched #(
  parameter int N_CH         = 2,
  parameter int LEVEL_WIDTH  = 11,
  parameter int PACKET_WORDS = 32,
  parameter int FLUSH_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_CH*LEVEL_WIDTH-1:0]   ch_level,
  output logic [N_CH-1:0]               ch_rd_en,
  output logic [1:0]                    ch_sel,
  input  logic [LEVEL_WIDTH-1:0]        rx_free,
  output logic                          rx_wr_en,
  input  logic                          txe_n,
  input  logic                          rxf_n,
  output logic                          wr_n,
  output logic                          rd_n,
  output logic                          oe_n,
  output logic                          burst_done,
  output logic                          burst_dir,
  output logic [$clog2(PACKET_WORDS):0] burst_words
);

  localparam int CW = $clog2(PACKET_WORDS) + 1;
  localparam int TW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [LEVEL_WIDTH-1:0] PKT_LVL   = LEVEL_WIDTH'(PACKET_WORDS);
  localparam logic [CW-1:0]          PKT_CNT   = CW'(PACKET_WORDS);
  localparam logic [TW-1:0]          FLUSH_MAX = TW'(FLUSH_CYCLES);
  localparam logic [1:0]             LAST_CH   = 2'(N_CH - 1);
  localparam logic [2:0]             N_CH_3    = 3'(N_CH);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_BURST = 3'd1,
    ST_WR_END   = 3'd2,
    ST_RD_OE    = 3'd3,
    ST_RD_BURST = 3'd4,
    ST_RD_END   = 3'd5
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [LEVEL_WIDTH-1:0]  level_s [4];
  logic [TW-1:0]           timer_r [N_CH];
  logic [3:0]              elig_s;
  logic [1:0]              rr_start_s;
  logic [2:0]              rr_sum_s;
  logic [1:0]              rr_idx_s;
  logic [1:0]              grant_idx_s;
  logic                    grant_found_s;
  logic [1:0]              last_grant_r;
  logic [1:0]              sel_r;
  logic [1:0]              sel_next_s;
  logic                    read_go_s;
  logic                    write_go_s;
  logic                    grant_evt_s;
  logic [CW-1:0]           len_r;
  logic [CW-1:0]           cnt_r;
  logic [CW-1:0]           cnt_inc_s;
  logic [CW-1:0]           final_cnt_s;
  logic [CW-1:0]           grant_len_s;
  logic [CW-1:0]           burst_words_r;
  logic                    burst_dir_r;
  logic                    wr_n_r, rd_n_r, oe_n_r, rx_wr_en_r, burst_done_r;
  logic                    wr_n_s, rd_n_s, oe_n_s, rx_wr_en_s, done_s;
  logic [N_CH-1:0]         rd_en_r;
  logic [N_CH-1:0]         rd_en_s;

  // Split the packed level bus into per-channel words (unused slots read as empty)
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      level_s[k] = {LEVEL_WIDTH{1'b0}};
    end
    for (int k = 0; k < N_CH; k++) begin
      level_s[k] = ch_level[k*LEVEL_WIDTH +: LEVEL_WIDTH];
    end
  end

  // A channel may burst when it holds a full packet or its flush timer expired
  always_comb begin
    elig_s = 4'b0000;
    for (int k = 0; k < N_CH; k++) begin
      elig_s[k] = (level_s[k] >= PKT_LVL) ||
                  ((level_s[k] != {LEVEL_WIDTH{1'b0}}) && (timer_r[k] == FLUSH_MAX));
    end
  end

  // Round-robin pick: walk from the lowest priority up so the first eligible
  // channel after last_grant is the one left standing
  always_comb begin
    rr_start_s    = (last_grant_r == LAST_CH) ? 2'd0 : last_grant_r + 2'd1;
    grant_idx_s   = 2'd0;
    grant_found_s = 1'b0;
    rr_sum_s      = 3'd0;
    rr_idx_s      = 2'd0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      rr_sum_s      = {1'b0, rr_start_s} + 3'(i);
      rr_idx_s      = (rr_sum_s >= N_CH_3) ? 2'(rr_sum_s - N_CH_3) : rr_sum_s[1:0];
      grant_idx_s   = elig_s[rr_idx_s] ? rr_idx_s : grant_idx_s;
      grant_found_s = grant_found_s | elig_s[rr_idx_s];
    end
  end

  // Launch conditions, burst length at grant and the word count of an ending burst
  always_comb begin
    read_go_s   = !rxf_n && (rx_free >= PKT_LVL);
    write_go_s  = !txe_n && grant_found_s;
    cnt_inc_s   = cnt_r + CW'(1);
    if (level_s[grant_idx_s] >= PKT_LVL) begin
      grant_len_s = PKT_CNT;
    end else begin
      grant_len_s = level_s[grant_idx_s][CW-1:0];
    end
    if (state_r == ST_WR_BURST) begin
      final_cnt_s = txe_n ? cnt_r : cnt_inc_s;
    end else begin
      final_cnt_s = rxf_n ? cnt_r : cnt_inc_s;
    end
    grant_evt_s = (state_r == ST_IDLE) && (state_s == ST_WR_BURST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; reads take priority over writes in IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (read_go_s) begin
          state_s = ST_RD_OE;
        end else if (write_go_s) begin
          state_s = ST_WR_BURST;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR_BURST: begin
        if (txe_n) begin
          state_s = ST_WR_END;
        end else if (cnt_inc_s == len_r) begin
          state_s = ST_WR_END;
        end else begin
          state_s = ST_WR_BURST;
        end
      end
      ST_WR_END:   state_s = ST_IDLE;
      ST_RD_OE:    state_s = ST_RD_BURST;
      ST_RD_BURST: begin
        if (rxf_n) begin
          state_s = ST_RD_END;
        end else if (cnt_inc_s == PKT_CNT) begin
          state_s = ST_RD_END;
        end else begin
          state_s = ST_RD_BURST;
        end
      end
      ST_RD_END:   state_s = ST_IDLE;
      default:     state_s = ST_IDLE;
    endcase
  end

  // Output logic: strobe values for the state being entered, registered below
  always_comb begin
    wr_n_s     = 1'b1;
    rd_n_s     = 1'b1;
    oe_n_s     = 1'b1;
    rx_wr_en_s = 1'b0;
    rd_en_s    = {N_CH{1'b0}};
    done_s     = 1'b0;
    sel_next_s = (state_r == ST_IDLE) ? grant_idx_s : sel_r;
    case (state_s)
      ST_WR_BURST: begin
        wr_n_s = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
          rd_en_s[k] = (sel_next_s == 2'(k));
        end
      end
      ST_RD_OE: oe_n_s = 1'b0;
      ST_RD_BURST: begin
        oe_n_s     = 1'b0;
        rd_n_s     = 1'b0;
        rx_wr_en_s = ~rxf_n;
      end
      ST_WR_END, ST_RD_END: done_s = 1'b1;
      default: done_s = 1'b0;
    endcase
  end

  // Strobe registers; a reset mid-burst drops every strobe on the next edge
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_n_r       <= 1'b1;
      rd_n_r       <= 1'b1;
      oe_n_r       <= 1'b1;
      rx_wr_en_r   <= 1'b0;
      rd_en_r      <= {N_CH{1'b0}};
      burst_done_r <= 1'b0;
    end else begin
      wr_n_r       <= wr_n_s;
      rd_n_r       <= rd_n_s;
      oe_n_r       <= oe_n_s;
      rx_wr_en_r   <= rx_wr_en_s;
      rd_en_r      <= rd_en_s;
      burst_done_r <= done_s;
    end
  end

  // Grant bookkeeping, word counter and the per-burst result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r         <= {CW{1'b0}};
      len_r         <= {CW{1'b0}};
      sel_r         <= 2'd0;
      last_grant_r  <= LAST_CH;
      burst_words_r <= {CW{1'b0}};
      burst_dir_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= {CW{1'b0}};
          if (grant_evt_s) begin
            sel_r        <= grant_idx_s;
            last_grant_r <= grant_idx_s;
            len_r        <= grant_len_s;
          end
        end
        ST_WR_BURST: begin
          if (!txe_n) begin
            cnt_r <= cnt_inc_s;
          end
          if (state_s == ST_WR_END) begin
            burst_words_r <= final_cnt_s;
            burst_dir_r   <= 1'b1;
          end
        end
        ST_RD_BURST: begin
          if (!rxf_n) begin
            cnt_r <= cnt_inc_s;
          end
          if (state_s == ST_RD_END) begin
            burst_words_r <= final_cnt_s;
            burst_dir_r   <= 1'b0;
          end
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Flush timers: count while a channel waits with data, clear when empty or served
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (reset) begin
        timer_r[k] <= {TW{1'b0}};
      end else if (level_s[k] == {LEVEL_WIDTH{1'b0}}) begin
        timer_r[k] <= {TW{1'b0}};
      end else if (grant_evt_s && (grant_idx_s == 2'(k))) begin
        timer_r[k] <= {TW{1'b0}};
      end else if (((state_r == ST_WR_BURST) || (state_r == ST_WR_END)) && (sel_r == 2'(k))) begin
        timer_r[k] <= {TW{1'b0}};
      end else if (timer_r[k] != FLUSH_MAX) begin
        timer_r[k] <= timer_r[k] + TW'(1);
      end
    end
  end

  assign wr_n        = wr_n_r;
  assign rd_n        = rd_n_r;
  assign oe_n        = oe_n_r;
  assign rx_wr_en    = rx_wr_en_r;
  assign ch_rd_en    = rd_en_r;
  assign ch_sel      = sel_r;
  assign burst_done  = burst_done_r;
  assign burst_dir   = burst_dir_r;
  assign burst_words = burst_words_r;

endmodule

// File: tb/tb_ft_burst_sched.sv
// Directed bench for ft_burst_sched with default parameters. Inputs change on
// the falling edge, outputs are sampled on the falling edge.
module tb_ft_burst_sched;
  localparam int NCH = 2;
  localparam int LW  = 11;
  localparam int PW  = 32;
  localparam int FC  = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH*LW-1:0] ch_level;
  logic [NCH-1:0]    ch_rd_en;
  logic [1:0]        ch_sel;
  logic [LW-1:0]     rx_free;
  logic              rx_wr_en;
  logic              txe_n, rxf_n;
  logic              wr_n, rd_n, oe_n;
  logic              burst_done, burst_dir;
  logic [5:0]        burst_words;

  int total = 0;
  int bad   = 0;
  int n;
  int excl;
  int seen;
  logic [1:0] exp_sel [3];

  always #5 clk = ~clk;

  ft_burst_sched #(.N_CH(NCH), .LEVEL_WIDTH(LW), .PACKET_WORDS(PW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .ch_level(ch_level), .ch_rd_en(ch_rd_en), .ch_sel(ch_sel),
    .rx_free(rx_free), .rx_wr_en(rx_wr_en), .txe_n(txe_n), .rxf_n(rxf_n),
    .wr_n(wr_n), .rd_n(rd_n), .oe_n(oe_n), .burst_done(burst_done),
    .burst_dir(burst_dir), .burst_words(burst_words)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_lv(input int l0, input int l1);
    ch_level = {LW'(l1), LW'(l0)};
  endtask

  task automatic wait_wr_low(input int limit, output int cnt);
    cnt = 0;
    while (wr_n !== 1'b0 && cnt < limit) begin
      tick();
      cnt++;
    end
  endtask

  task automatic count_low(output int cnt);
    cnt = 0;
    while (wr_n === 1'b0 && cnt < 100) begin
      cnt++;
      tick();
    end
  endtask

  task automatic wait_done(input int limit, output int cnt);
    cnt = 0;
    while (burst_done !== 1'b1 && cnt < limit) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    exp_sel[0] = 2'd0; exp_sel[1] = 2'd1; exp_sel[2] = 2'd0;
    reset = 1'b1; ch_level = '0; rx_free = '0; txe_n = 1'b1; rxf_n = 1'b1;
    @(negedge clk);
    repeat (3) tick();
    chk("rst_wr_n", 32'(wr_n), 32'd1);
    chk("rst_rd_n", 32'(rd_n), 32'd1);
    chk("rst_oe_n", 32'(oe_n), 32'd1);
    chk("rst_rd_en", 32'(ch_rd_en), 32'd0);
    chk("rst_rx_wr_en", 32'(rx_wr_en), 32'd0);
    chk("rst_done", 32'(burst_done), 32'd0);
    chk("rst_dir", 32'(burst_dir), 32'd0);
    chk("rst_words", 32'(burst_words), 32'd0);
    chk("rst_sel", 32'(ch_sel), 32'd0);
    reset = 1'b0;
    tick();

    // full write burst from ch0 (level 40)
    set_lv(40, 0); txe_n = 1'b0;
    wait_wr_low(10, n);
    chk("t1_start", 32'(wr_n), 32'd0);
    chk("t1_rd_en", 32'(ch_rd_en), 32'd1);
    chk("t1_sel", 32'(ch_sel), 32'd0);
    set_lv(0, 0);
    count_low(n);
    chk("t1_len", n, 32'd32);
    chk("t1_done", 32'(burst_done), 32'd1);
    chk("t1_words", 32'(burst_words), 32'd32);
    chk("t1_dir", 32'(burst_dir), 32'd1);
    chk("t1_rd_en_off", 32'(ch_rd_en), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(burst_done), 32'd0);
    chk("t1_words_held", 32'(burst_words), 32'd32);

    // partial burst: txe_n rises after 10 words
    set_lv(40, 0);
    wait_wr_low(10, n);
    chk("t2_start", 32'(wr_n), 32'd0);
    set_lv(0, 0);
    repeat (10) tick();
    chk("t2_mid", 32'(wr_n), 32'd0);
    txe_n = 1'b1;
    tick();
    chk("t2_wr_n", 32'(wr_n), 32'd1);
    chk("t2_rd_en", 32'(ch_rd_en), 32'd0);
    chk("t2_done", 32'(burst_done), 32'd1);
    chk("t2_words", 32'(burst_words), 32'd10);
    tick();

    // reset at word 5 of the following burst
    txe_n = 1'b0; set_lv(40, 0);
    wait_wr_low(10, n);
    chk("t3_start", 32'(wr_n), 32'd0);
    set_lv(0, 0);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk("t3_wr_n", 32'(wr_n), 32'd1);
    chk("t3_rd_en", 32'(ch_rd_en), 32'd0);
    chk("t3_done", 32'(burst_done), 32'd0);
    reset = 1'b0; txe_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (burst_done === 1'b1) seen++;
    end
    chk("t3_no_done", seen, 32'd0);
    chk("t3_words_clr", 32'(burst_words), 32'd0);

    // round robin over three back-to-back bursts
    txe_n = 1'b0; set_lv(40, 40);
    for (int b = 0; b < 3; b++) begin
      wait_done(100, n);
      chk("t4_done", 32'(burst_done), 32'd1);
      chk("t4_sel", 32'(ch_sel), 32'(exp_sel[b]));
      if (b == 2) begin
        set_lv(0, 0); txe_n = 1'b1;
      end
      tick();
      chk("t4_gap", 32'(wr_n), 32'd1);
    end

    // flush of a 5-word partial packet on ch1
    set_lv(0, 5); txe_n = 1'b0;
    wait_wr_low(FC + 50, n);
    chk("t5_delay", n, 32'(FC + 1));
    chk("t5_sel", 32'(ch_sel), 32'd1);
    chk("t5_rd_en", 32'(ch_rd_en), 32'd2);
    set_lv(0, 0);
    count_low(n);
    chk("t5_len", n, 32'd5);
    chk("t5_done", 32'(burst_done), 32'd1);
    chk("t5_words", 32'(burst_words), 32'd5);
    tick();

    // not enough room in the host-to-device FIFO: no read
    txe_n = 1'b1; rxf_n = 1'b0; rx_free = LW'(20);
    repeat (3) tick();
    chk("t6_no_read", 32'(oe_n), 32'd1);

    // read and write both ready: read first
    rx_free = LW'(100); txe_n = 1'b0; set_lv(64, 0);
    tick();
    chk("t7_oe", 32'(oe_n), 32'd0);
    chk("t7_rd_hi", 32'(rd_n), 32'd1);
    chk("t7_wr_idle", 32'(wr_n), 32'd1);
    tick();
    chk("t7_rd_lo", 32'(rd_n), 32'd0);
    excl = 0; n = 0;
    while (rx_wr_en === 1'b1 && n < 100) begin
      if (wr_n !== 1'b1) excl++;
      n++;
      tick();
    end
    chk("t7_rx_pulses", n, 32'd32);
    chk("t7_exclusive", excl, 32'd0);
    chk("t7_done", 32'(burst_done), 32'd1);
    chk("t7_dir", 32'(burst_dir), 32'd0);
    chk("t7_words", 32'(burst_words), 32'd32);
    chk("t7_oe_off", 32'(oe_n), 32'd1);
    rxf_n = 1'b1;
    tick();
    chk("t7_end_gap", 32'(wr_n), 32'd1);
    tick();
    chk("t7_wr_follow", 32'(wr_n), 32'd0);
    chk("t7_wr_sel", 32'(ch_sel), 32'd0);
    set_lv(0, 0);
    count_low(n);
    chk("t7_wr_len", n, 32'd32);
    chk("t7_wr_done", 32'(burst_done), 32'd1);
    tick();

    // zero-word write burst
    set_lv(40, 0);
    wait_wr_low(10, n);
    txe_n = 1'b1; set_lv(0, 0);
    tick();
    chk("t8_wdone", 32'(burst_done), 32'd1);
    chk("t8_wwords", 32'(burst_words), 32'd0);
    chk("t8_wdir", 32'(burst_dir), 32'd1);
    tick();

    // zero-word read burst
    rxf_n = 1'b0;
    tick();
    chk("t8_oe", 32'(oe_n), 32'd0);
    rxf_n = 1'b1;
    tick();
    chk("t8_rd_n", 32'(rd_n), 32'd0);
    chk("t8_rx_wr_en", 32'(rx_wr_en), 32'd0);
    tick();
    chk("t8_rdone", 32'(burst_done), 32'd1);
    chk("t8_rwords", 32'(burst_words), 32'd0);
    chk("t8_rdir", 32'(burst_dir), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
